fifo_drain_serializer: RTL and testbench

FIFO_DRAIN_SERIALIZER -- requirements
Module: fifo_drain_serializer

---
 rtl/fifo_drain_pkg.sv | 16 +
 rtl/fifo_drain_serializer_word_byte_shifter.sv | 39 +++
 rtl/fifo_drain_serializer.sv | 121 ++++++++++++
 tb/tb_fifo_drain_serializer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared widths and FSM state type for the FIFO drain serializer.
package fifo_drain_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_drain_serializer_word_byte_shifter.sv
// Holds one 32-bit word and presents it a byte at a time, LSB-first
// (BYTE_ORDER=0) or MSB-first (BYTE_ORDER=1).
module word_byte_shifter
    import fifo_drain_pkg::*;
#(
    parameter int unsigned BYTE_ORDER = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [WORD_W-1:0] word,
    output logic [BYTE_W-1:0] cur_byte,
    output logic [IDX_W-1:0]  index
);

    logic [WORD_W-1:0] sr;

    // The byte on show is always at a fixed end of the register; advancing shifts the next one in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr    <= '0;
            index <= '0;
        end else if (load) begin
            sr    <= word;
            index <= '0;
        end else if (advance) begin
            index <= index + 1'b1;
            if (BYTE_ORDER == 0) begin
                sr <= {{BYTE_W{1'b0}}, sr[WORD_W-1:BYTE_W]};
            end else begin
                sr <= {sr[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            end
        end
    end

    assign cur_byte = (BYTE_ORDER == 0) ? sr[BYTE_W-1:0] : sr[WORD_W-1 -: BYTE_W];

endmodule

// File: rtl/fifo_drain_serializer.sv
// Drains 32-bit words from an upstream FIFO and emits them as 4 bytes on a
// valid/ready stream. Optional parity output enabled by `define SER_PARITY_EN.
module fifo_drain_serializer
    import fifo_drain_pkg::*;
#(
    parameter int unsigned BYTE_ORDER = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_data_avail_i,
    input  logic              fifo_empty_i,
    input  logic              fifo_flush_i,
    input  logic [WORD_W-1:0] fifo_rd_data_i,
    output logic              fifo_rd_valid_o,
    input  logic              abort_i,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [BYTE_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              busy_o,
`ifdef SER_PARITY_EN
    output logic              out_parity_o,
`endif
    output logic [CNT_W-1:0]  word_count_o
);

    state_t            state;
    state_t            next_state;
    logic              armed;
    logic              load;
    logic              advance;
    logic              word_done;
    logic              last_byte;
    logic [BYTE_W-1:0] cur_byte;
    logic [IDX_W-1:0]  index;

    // armed holds off the first read for one edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= next_state;
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_count_o <= '0;
        end else if (word_done) begin
            word_count_o <= word_count_o + 1'b1;
        end
    end

    assign last_byte = (index == IDX_W'(BYTES_PER_WORD - 1));

    // Abort takes priority over every handshake, including the last byte.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        advance    = 1'b0;
        word_done  = 1'b0;
        case (state)
            IDLE: begin
                if (armed && fifo_data_avail_i && !fifo_empty_i && !fifo_flush_i) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (abort_i) begin
                    next_state = IDLE;
                end else begin
                    load       = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                if (abort_i) begin
                    next_state = IDLE;
                end else if (out_ready_i) begin
                    advance = 1'b1;
                    if (last_byte) begin
                        word_done  = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    word_byte_shifter #(
        .BYTE_ORDER (BYTE_ORDER)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .advance  (advance),
        .word     (fifo_rd_data_i),
        .cur_byte (cur_byte),
        .index    (index)
    );

    assign fifo_rd_valid_o = (state == REQ);
    assign busy_o          = (state != IDLE);
    assign out_valid_o     = (state == SEND);
    assign out_data_o      = out_valid_o ? cur_byte : '0;
    assign out_last_o      = out_valid_o & last_byte;

`ifdef SER_PARITY_EN
    assign out_parity_o = ^out_data_o;
`endif

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Drives an LSB-first/16-bit-count DUT and an MSB-first/3-bit-count DUT from the
// same stimulus and checks both against a word-level model of the byte stream.
module tb_fifo_drain_serializer;

    localparam int unsigned CNT_W_A = 16;
    localparam int unsigned CNT_W_B = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_data_avail_i;
    logic        fifo_empty_i;
    logic        fifo_flush_i;
    logic [31:0] fifo_rd_data_i;
    logic        abort_i;
    logic        out_ready_i;

    logic               rd_a, rd_b, val_a, val_b, last_a, last_b, busy_a, busy_b;
    logic [7:0]         data_a, data_b;
    logic [CNT_W_A-1:0] cnt_a;
    logic [CNT_W_B-1:0] cnt_b;
`ifdef SER_PARITY_EN
    logic               par_a, par_b;
`endif

    int          checks   = 0;
    int          failures = 0;
    int unsigned words_done = 0;

    always #5 clk = ~clk;

    fifo_drain_serializer #(.BYTE_ORDER(0), .CNT_W(CNT_W_A)) dut_lsb (
        .clk(clk), .reset(reset),
        .fifo_data_avail_i(fifo_data_avail_i), .fifo_empty_i(fifo_empty_i),
        .fifo_flush_i(fifo_flush_i), .fifo_rd_data_i(fifo_rd_data_i),
        .fifo_rd_valid_o(rd_a), .abort_i(abort_i), .out_ready_i(out_ready_i),
        .out_valid_o(val_a), .out_data_o(data_a), .out_last_o(last_a), .busy_o(busy_a),
`ifdef SER_PARITY_EN
        .out_parity_o(par_a),
`endif
        .word_count_o(cnt_a)
    );

    fifo_drain_serializer #(.BYTE_ORDER(1), .CNT_W(CNT_W_B)) dut_msb (
        .clk(clk), .reset(reset),
        .fifo_data_avail_i(fifo_data_avail_i), .fifo_empty_i(fifo_empty_i),
        .fifo_flush_i(fifo_flush_i), .fifo_rd_data_i(fifo_rd_data_i),
        .fifo_rd_valid_o(rd_b), .abort_i(abort_i), .out_ready_i(out_ready_i),
        .out_valid_o(val_b), .out_data_o(data_b), .out_last_o(last_b), .busy_o(busy_b),
`ifdef SER_PARITY_EN
        .out_parity_o(par_b),
`endif
        .word_count_o(cnt_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Byte k of a word in emit order: LSB-first takes bits 8k+7:8k, MSB-first mirrors it.
    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int order, input int k);
        int sh;
        sh = (order == 0) ? 8 * k : 8 * (3 - k);
        return 8'((w >> sh) & 32'hFF);
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, "_ctl"}, {rd_a, rd_b, val_a, val_b, last_a, last_b, busy_a, busy_b}, 0);
        check_eq({tag, "_data"}, {data_a, data_b}, 0);
`ifdef SER_PARITY_EN
        check_eq({tag, "_par"}, {par_a, par_b}, 0);
`endif
        check_eq({tag, "_cnt16"}, 32'(cnt_a), words_done % 65536);
        check_eq({tag, "_cnt3"}, 32'(cnt_b), words_done % 8);
    endtask

    // Called on a falling edge with the DUTs idle. idle_cycles: falling edges on
    // which the strobe must still be low with avail held. abort_at/reset_at: byte
    // index at which to abort or pulse reset (-1 = never).
    task automatic deliver_word(input logic [31:0] w, input int idle_cycles,
                                input int abort_at, input int ready_mode, input int reset_at);
        int  idx;
        int  cycles;
        bit  rdy;
        bit  toggle;
        bit  ended;
        idx    = 0;
        cycles = 0;
        toggle = 1'b0;
        ended  = 1'b0;
        fifo_data_avail_i = 1'b1;
        fifo_empty_i      = 1'b0;
        fifo_flush_i      = 1'b0;
        for (int c = 0; c < idle_cycles; c++) begin
            check_eq("no_strobe_yet", {rd_a, rd_b, busy_a, busy_b}, 0);
            abort_i = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check_eq("strobe", {rd_a, rd_b, busy_a, busy_b, val_a, val_b}, 6'b111100);
        fifo_data_avail_i = 1'($urandom_range(0, 1));
        fifo_rd_data_i    = $urandom;
        abort_i           = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_eq("wait_phase", {rd_a, rd_b, busy_a, busy_b, val_a, val_b}, 6'b001100);
        fifo_rd_data_i    = w;
        abort_i           = 1'b0;
        fifo_data_avail_i = 1'b1;
        @(negedge clk);
        fifo_rd_data_i = $urandom;
        while (!ended && idx < 4 && cycles < 64) begin
            cycles++;
            check_eq("valid", {val_a, val_b}, 2'b11);
            check_eq("byte_lsb", data_a, exp_byte(w, 0, idx));
            check_eq("byte_msb", data_b, exp_byte(w, 1, idx));
            check_eq("last", {last_a, last_b}, (idx == 3) ? 2'b11 : 2'b00);
`ifdef SER_PARITY_EN
            check_eq("parity", {par_a, par_b}, {^exp_byte(w, 0, idx), ^exp_byte(w, 1, idx)});
`endif
            if (idx == reset_at) begin
                #2 reset = 1'b0;
                words_done = 0;
                #1 check_quiet("async_reset");
                @(negedge clk);
                reset       = 1'b1;
                out_ready_i = 1'b0;
                return;
            end
            fifo_flush_i = 1'($urandom_range(0, 1));
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: begin rdy = toggle; toggle = ~toggle; end
            endcase
            if (idx == abort_at) begin
                rdy     = 1'b1;
                abort_i = 1'b1;
            end
            out_ready_i = rdy;
            @(negedge clk);
            if (abort_i) ended = 1'b1;
            else if (rdy) idx++;
            abort_i = 1'b0;
        end
        if (!ended && idx < 4) check_eq("send_timeout", idx, 4);
        if (idx == 4) words_done++;
        out_ready_i = 1'($urandom_range(0, 1));
        check_quiet("word_end");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b0;
        fifo_data_avail_i = 1'b0;
        fifo_empty_i      = 1'b1;
        fifo_flush_i      = 1'b0;
        fifo_rd_data_i    = '0;
        abort_i           = 1'b0;
        out_ready_i       = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset_state");
        reset = 1'b1;

        deliver_word(32'h8A6A_0A38, 2, -1, 0, -1);
        deliver_word(32'h8A6A_0A38, 1, -1, 2, -1);

        fifo_flush_i      = 1'b1;
        fifo_data_avail_i = 1'b1;
        fifo_empty_i      = 1'b0;
        repeat (5) begin
            check_eq("flush_blocks", {rd_a, rd_b, busy_a}, 0);
            @(negedge clk);
        end
        deliver_word($urandom, 1, -1, 1, -1);

        fifo_empty_i      = 1'b1;
        fifo_data_avail_i = 1'b1;
        repeat (3) begin
            check_eq("empty_blocks", {rd_a, rd_b, busy_a}, 0);
            @(negedge clk);
        end
        deliver_word($urandom, 1, -1, 1, -1);

        deliver_word($urandom, 1, 1, 0, -1);
        deliver_word(32'h8A6A_0A38, 1, -1, 0, -1);
        deliver_word($urandom, 1, 3, 0, -1);
        deliver_word(32'h8A6A_0A38, 1, -1, 1, 2);
        deliver_word(32'h8A6A_0A38, 2, -1, 1, -1);

        for (int n = 0; n < 30; n++) begin
            int gap;
            int ab;
            gap = int'($urandom_range(0, 3));
            ab  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
            fifo_data_avail_i = 1'b0;
            for (int g = 0; g < gap; g++) begin
                check_eq("no_avail_idle", {rd_a, rd_b, busy_a}, 0);
                @(negedge clk);
            end
            deliver_word($urandom, 1, ab, int'($urandom_range(0, 2)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
